// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared types and constants for the 8259 interrupt sequencer
package pic_pkg;
    localparam int IRQ_W = 8;
    localparam int LVL_W = 3;
    localparam logic [LVL_W-1:0] SPURIOUS_LVL = 3'd7;
    localparam logic [7:0] DEF_VEC_BASE = 8'h08;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ACK1,
        WAIT2,
        ACK2
    } pic_state_t;
endpackage

// File: rtl/pic_prio_enc.sv
// rtl/pic_prio_enc.sv - lowest-index-first priority encoder, {valid, level}
module pic_prio_enc
    import pic_pkg::*;
(
    input  logic [IRQ_W-1:0] vec,
    output logic             valid,
    output logic [LVL_W-1:0] level
);

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        valid = 1'b0;
        level = '0;
        for (int i = IRQ_W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                valid = 1'b1;
                level = LVL_W'(i);
            end
        end
    end

endmodule

// File: rtl/pic_int_sequencer.sv
// rtl/pic_int_sequencer.sv - 8259 priority/INTA/EOI sequencer; option macro PIC_AUTO_EOI_EN
module pic_int_sequencer
    import pic_pkg::*;
#(
    parameter int          NUM_IRQ  = IRQ_W,
    parameter logic [7:0]  VEC_BASE = DEF_VEC_BASE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic               inta_n,
    input  logic               eoi_wr,
    input  logic               eoi_specific,
    input  logic [LVL_W-1:0]   eoi_level,
    input  logic               base_wr,
    input  logic [4:0]         base_din,
    output logic               intr,
    output logic [7:0]         vec_out,
    output logic               vec_oe,
    output logic [NUM_IRQ-1:0] irr_clr,
    output logic [NUM_IRQ-1:0] isr
);

    pic_state_t         state, next_state;
    logic               inta_q;
    logic               inta_fall, inta_rise;
    logic               req_valid, isr_valid;
    logic [LVL_W-1:0]   req_lvl, isr_lvl;
    logic               eligible;
    logic               take_ack, load_vec;
    logic [LVL_W-1:0]   winner;
    logic [4:0]         base;
    logic [NUM_IRQ-1:0] set_mask, clr_mask, isr_nxt;
`ifdef PIC_AUTO_EOI_EN
    logic               spurious;
`endif

    assign inta_fall = inta_q & ~inta_n;
    assign inta_rise = ~inta_q & inta_n;

    pic_prio_enc u_req_enc (.vec(irq_req), .valid(req_valid), .level(req_lvl));
    pic_prio_enc u_isr_enc (.vec(isr),     .valid(isr_valid), .level(isr_lvl));

    // Fully nested: an in-service level blocks itself and everything below it.
    assign eligible = req_valid && (!isr_valid || (req_lvl < isr_lvl));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        take_ack   = 1'b0;
        load_vec   = 1'b0;
        case (state)
            IDLE:  if (eligible) next_state = REQ;
            REQ:   if (inta_fall) begin
                       take_ack   = 1'b1;
                       next_state = ACK1;
                   end
            ACK1:  if (inta_rise) next_state = WAIT2;
            WAIT2: if (inta_fall) begin
                       load_vec   = 1'b1;
                       next_state = ACK2;
                   end
            ACK2:  if (inta_rise) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (take_ack && eligible)
            set_mask = NUM_IRQ'(1) << req_lvl;
        if (eoi_wr) begin
            if (eoi_specific)
                clr_mask = NUM_IRQ'(1) << eoi_level;
            else if (isr_valid)
                clr_mask = NUM_IRQ'(1) << isr_lvl;
        end
`ifdef PIC_AUTO_EOI_EN
        if (state == ACK2 && inta_rise && !spurious)
            clr_mask = clr_mask | (NUM_IRQ'(1) << winner);
`endif
        // Set is applied after clear so it wins on a shared bit.
        isr_nxt = (isr & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inta_q   <= 1'b1;
            isr      <= '0;
            irr_clr  <= '0;
            vec_out  <= '0;
            winner   <= '0;
            base     <= VEC_BASE[7:3];
`ifdef PIC_AUTO_EOI_EN
            spurious <= 1'b0;
`endif
        end else begin
            inta_q  <= inta_n;
            isr     <= isr_nxt;
            irr_clr <= set_mask;
            if (take_ack) begin
                winner   <= eligible ? req_lvl : SPURIOUS_LVL;
`ifdef PIC_AUTO_EOI_EN
                spurious <= !eligible;
`endif
            end
            if (load_vec) vec_out <= {base, winner};
            if (base_wr)  base    <= base_din;
        end
    end

    assign intr   = (state == REQ);
    assign vec_oe = (state == ACK2);

endmodule

// File: tb/tb_pic_int_sequencer.sv
// tb/tb_pic_int_sequencer.sv - directed scoreboard bench for pic_int_sequencer
module tb_pic_int_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irq_req;
    logic       inta_n;
    logic       eoi_wr;
    logic       eoi_specific;
    logic [2:0] eoi_level;
    logic       base_wr;
    logic [4:0] base_din;
    logic       intr;
    logic [7:0] vec_out;
    logic       vec_oe;
    logic [7:0] irr_clr;
    logic [7:0] isr;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_clr_q[$];
    logic [7:0] exp_vec_q[$];

    pic_int_sequencer dut (
        .clk(clk), .reset(reset), .irq_req(irq_req), .inta_n(inta_n),
        .eoi_wr(eoi_wr), .eoi_specific(eoi_specific), .eoi_level(eoi_level),
        .base_wr(base_wr), .base_din(base_din), .intr(intr), .vec_out(vec_out),
        .vec_oe(vec_oe), .irr_clr(irr_clr), .isr(isr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_underflow(input string tag);
        n_tests++;
        n_fail++;
        $display("FAIL %s: scoreboard empty, observed none expected entry", tag);
    endtask

    // First INTA pulse: DUT answers with irr_clr/ISR update one cycle later.
    task automatic inta_pulse1(input logic [7:0] exp_isr);
        inta_n = 1'b0;
        tick();
        if (exp_clr_q.size() == 0) sb_underflow("irr_clr");
        else check("irr_clr", irr_clr, exp_clr_q.pop_front());
        check("isr_after_ack1", isr, exp_isr);
        check("intr_dropped", {7'b0, intr}, 8'h00);
        tick();
        check("irr_clr_one_cycle", irr_clr, 8'h00);
        inta_n = 1'b1;
        tick();
        tick();
    endtask

    // Second INTA pulse: vector driven while inta_n is low, held after.
    task automatic inta_pulse2();
        logic [7:0] exp_v;
        inta_n = 1'b0;
        tick();
        if (exp_vec_q.size() == 0) begin
            sb_underflow("vec_out");
            exp_v = 8'h00;
        end else begin
            exp_v = exp_vec_q.pop_front();
            check("vec_out", vec_out, exp_v);
        end
        check("vec_oe_on", {7'b0, vec_oe}, 8'h01);
        tick();
        check("vec_oe_hold", {7'b0, vec_oe}, 8'h01);
        inta_n = 1'b1;
        tick();
        check("vec_oe_off", {7'b0, vec_oe}, 8'h00);
        check("vec_out_held", vec_out, exp_v);
    endtask

    task automatic eoi(input logic specific, input logic [2:0] lvl);
        eoi_wr       = 1'b1;
        eoi_specific = specific;
        eoi_level    = lvl;
        tick();
        eoi_wr       = 1'b0;
        eoi_specific = 1'b0;
    endtask

    initial begin
        reset = 1'b1; irq_req = 8'h00; inta_n = 1'b1; eoi_wr = 1'b0;
        eoi_specific = 1'b0; eoi_level = 3'd0; base_wr = 1'b0; base_din = 5'h00;
        #1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_intr", {7'b0, intr}, 8'h00);
        check("rst_vec_oe", {7'b0, vec_oe}, 8'h00);
        check("rst_isr", isr, 8'h00);
        check("rst_irr_clr", irr_clr, 8'h00);
        check("rst_vec_out", vec_out, 8'h00);

        // IR0 basic handshake
        irq_req = 8'h01;
        tick();
        check("ir0_intr", {7'b0, intr}, 8'h01);
        exp_clr_q.push_back(8'h01);
        inta_pulse1(8'h01);
        irq_req = 8'h00;
        exp_vec_q.push_back(8'h08);
        inta_pulse2();
        check("ir0_isr_kept", isr, 8'h01);
        eoi(1'b0, 3'd0);
        check("ir0_eoi", isr, 8'h00);

        // IR2 in service blocks IR3 and IR5
        irq_req = 8'h04;
        tick();
        exp_clr_q.push_back(8'h04);
        inta_pulse1(8'h04);
        irq_req = 8'h00;
        exp_vec_q.push_back(8'h0A);
        inta_pulse2();
        irq_req = 8'h28;
        tick();
        tick();
        check("nested_block", {7'b0, intr}, 8'h00);
        eoi(1'b0, 3'd0);
        check("nested_eoi", isr, 8'h00);
        tick();
        check("ir3_intr", {7'b0, intr}, 8'h01);
        exp_clr_q.push_back(8'h08);
        inta_pulse1(8'h08);
        irq_req = 8'h20;
        exp_vec_q.push_back(8'h0B);
        inta_pulse2();
        check("ir5_blocked", {7'b0, intr}, 8'h00);
        irq_req = 8'h00;
        eoi(1'b0, 3'd0);
        check("ir3_eoi", isr, 8'h00);

        // Spurious: request withdrawn before first INTA
        irq_req = 8'h10;
        tick();
        check("spur_intr", {7'b0, intr}, 8'h01);
        irq_req = 8'h00;
        tick();
        check("spur_intr_stays", {7'b0, intr}, 8'h01);
        exp_clr_q.push_back(8'h00);
        inta_pulse1(8'h00);
        exp_vec_q.push_back(8'h0F);
        inta_pulse2();
        check("spur_isr", isr, 8'h00);

        // New base, IR6, specific EOI
        base_wr = 1'b1; base_din = 5'h0D;
        tick();
        base_wr = 1'b0;
        irq_req = 8'h40;
        tick();
        exp_clr_q.push_back(8'h40);
        inta_pulse1(8'h40);
        irq_req = 8'h00;
        exp_vec_q.push_back(8'h6E);
        inta_pulse2();
        eoi(1'b1, 3'd2);
        check("spec_eoi_clear_bit", isr, 8'h40);
        eoi(1'b1, 3'd6);
        check("spec_eoi6", isr, 8'h00);

        // Reset while waiting for the second INTA
        irq_req = 8'h01;
        tick();
        exp_clr_q.push_back(8'h01);
        inta_pulse1(8'h01);
        irq_req = 8'h00;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("wrst_intr", {7'b0, intr}, 8'h00);
        check("wrst_vec_oe", {7'b0, vec_oe}, 8'h00);
        check("wrst_isr", isr, 8'h00);
        check("wrst_irr_clr", irr_clr, 8'h00);
        inta_n = 1'b0;
        tick();
        check("wrst_no_vec1", {7'b0, vec_oe}, 8'h00);
        inta_n = 1'b1;
        tick();
        inta_n = 1'b0;
        tick();
        check("wrst_no_vec2", {7'b0, vec_oe}, 8'h00);
        inta_n = 1'b1;
        tick();

        // IR1 with default base after reset; ISR depends on auto-EOI option
        irq_req = 8'h02;
        tick();
        exp_clr_q.push_back(8'h02);
        inta_pulse1(8'h02);
        irq_req = 8'h00;
        exp_vec_q.push_back(8'h09);
        inta_pulse2();
`ifdef PIC_AUTO_EOI_EN
        check("auto_eoi_isr", isr, 8'h00);
`else
        check("no_auto_eoi_isr", isr, 8'h02);
`endif
        eoi(1'b0, 3'd0);
        check("final_isr", isr, 8'h00);
        check("sb_drained", 8'(exp_clr_q.size() + exp_vec_q.size()), 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
